// File: rtl/inv_sub_bytes.sv
// AES inverse SubBytes over a 128-bit block, COLS_PER_CYCLE columns per clock.
// Define INV_SUB_BYTES_BUSY_EN to add the busy_out status port.
module inv_sub_bytes #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start,
    input  logic [127:0] block_in,
    output logic [127:0] result_out,
    output logic         valid_out
`ifdef INV_SUB_BYTES_BUSY_EN
    ,
    output logic         busy_out
`endif
);

    typedef enum logic [1:0] {IDLE, SUB, OUTPUT} state_t;

    localparam logic [2:0] LAST_COL = 3'd4;
    localparam logic [2:0] STEP     = 3'(COLS_PER_CYCLE);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    state_t       state;
    logic [2:0]   col_cnt;
    logic [127:0] block_q;
    logic [127:0] acc;
    logic [127:0] sub_all;

    // All 16 lookups are decoded every cycle; SUB commits only the current column window.
    always_comb begin
        sub_all = '0;
        for (int unsigned i = 0; i < 16; i++)
            sub_all[i*8 +: 8] = INV_SBOX[block_q[i*8 +: 8]];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            col_cnt    <= '0;
            block_q    <= '0;
            acc        <= '0;
            result_out <= '0;
            valid_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_out <= 1'b0;
                    if (start) begin
                        block_q <= block_in;
                        col_cnt <= '0;
                        state   <= SUB;
                    end
                end
                SUB: begin
                    if (col_cnt == LAST_COL) begin
                        result_out <= acc;
                        valid_out  <= 1'b1;
                        state      <= OUTPUT;
                    end else begin
                        for (int unsigned c = 0; c < 4; c++)
                            if (c >= 32'(col_cnt) && c < 32'(col_cnt) + COLS_PER_CYCLE)
                                acc[c*32 +: 32] <= sub_all[c*32 +: 32];
                        col_cnt <= col_cnt + STEP;
                    end
                end
                OUTPUT: begin
                    valid_out <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    valid_out <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef INV_SUB_BYTES_BUSY_EN
    assign busy_out = (state != IDLE);
`endif

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Scoreboard bench for inv_sub_bytes at 1, 2 and 4 columns per cycle with hand-computed vectors.
// Busy checks are compiled in when INV_SUB_BYTES_BUSY_EN is defined.
module tb_inv_sub_bytes;

    typedef struct {
        logic [127:0] data;
        int           edge_no;
    } exp_t;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         start;
    logic [127:0] block_in;
    logic [127:0] res1, res2, res4;
    logic         val1, val2, val4;
`ifdef INV_SUB_BYTES_BUSY_EN
    logic         busy1, busy2, busy4;
`endif

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q [3][$];
    logic prev_v [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;

    inv_sub_bytes #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .block_in(block_in),
        .result_out(res1), .valid_out(val1)
`ifdef INV_SUB_BYTES_BUSY_EN
        , .busy_out(busy1)
`endif
    );
    inv_sub_bytes #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .block_in(block_in),
        .result_out(res2), .valid_out(val2)
`ifdef INV_SUB_BYTES_BUSY_EN
        , .busy_out(busy2)
`endif
    );
    inv_sub_bytes #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .block_in(block_in),
        .result_out(res4), .valid_out(val4)
`ifdef INV_SUB_BYTES_BUSY_EN
        , .busy_out(busy4)
`endif
    );

    task automatic mon(input int id, input logic v, input logic [127:0] r);
        exp_t e;
        if (v) begin
            checks++;
            if (prev_v[id]) begin
                errors++;
                $display("FAIL valid_width dut%0d: valid high again at edge %0d, required single-cycle pulse", id, cyc);
            end
            checks++;
            if (q[id].size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid dut%0d: valid at edge %0d, required no pending block", id, cyc);
            end else begin
                e = q[id].pop_front();
                if (r !== e.data || cyc != e.edge_no) begin
                    errors++;
                    $display("FAIL result dut%0d: got %h at edge %0d, required %h at edge %0d",
                             id, r, cyc, e.data, e.edge_no);
                end
            end
        end
        prev_v[id] = v;
    endtask

    always @(posedge clk_in) begin #1; mon(0, val1, res1); end
    always @(posedge clk_in) begin #1; mon(1, val2, res2); end
    always @(posedge clk_in) begin #1; mon(2, val4, res4); end

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input int n, input logic [127:0] exp, input bit p1, input bit p2, input bit p4);
        exp_t e;
        e.data = exp;
        if (p1) begin e.edge_no = n + 5; q[0].push_back(e); end
        if (p2) begin e.edge_no = n + 3; q[1].push_back(e); end
        if (p4) begin e.edge_no = n + 2; q[2].push_back(e); end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic issue(input logic [127:0] blk, input logic [127:0] exp);
        @(negedge clk_in);
        start    = 1'b1;
        block_in = blk;
        push(cyc + 1, exp, 1'b1, 1'b1, 1'b1);
        @(negedge clk_in);
        start = 1'b0;
        idle(7);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_res1"}, res1, '0);
        check_eq({tag, "_res2"}, res2, '0);
        check_eq({tag, "_res4"}, res4, '0);
        check_eq({tag, "_val"}, {125'd0, val1, val2, val4}, '0);
`ifdef INV_SUB_BYTES_BUSY_EN
        check_eq({tag, "_busy"}, {125'd0, busy1, busy2, busy4}, '0);
`endif
    endtask

    localparam logic [127:0] BYTE_IDX     = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] BYTE_IDX_INV = 128'hfbd7f3819ea340bf38a53630d56a0952;
    localparam logic [127:0] COL_MIX      = {32'h01010101, 32'h00000000, 32'hffffffff, 32'h63636363};
    localparam logic [127:0] COL_MIX_INV  = {32'h09090909, 32'h52525252, 32'h7d7d7d7d, 32'h00000000};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rst_in   = 1'b0;
        start    = 1'b0;
        block_in = '0;
        idle(3);
        check_zero_outputs("reset");
        rst_in = 1'b1;
        idle(2);

`ifdef INV_SUB_BYTES_BUSY_EN
        // busy must cover the window from the capture edge up to the edge leaving OUTPUT
        @(negedge clk_in);
        check_eq("busy_before", {127'd0, busy1}, 128'd0);
        start    = 1'b1;
        block_in = '0;
        push(cyc + 1, {16{8'h52}}, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_in);
            start = 1'b0;
            check_eq($sformatf("busy_k%0d", k), {127'd0, busy1}, 128'd1);
        end
        @(negedge clk_in);
        check_eq("busy_after", {127'd0, busy1}, 128'd0);
        idle(3);
`else
        issue('0, {16{8'h52}});
`endif

        issue(BYTE_IDX, BYTE_IDX_INV);
        issue({16{8'h63}}, '0);
        issue({16{8'hff}}, {16{8'h7d}});
        issue(COL_MIX, COL_MIX_INV);
        check_eq("hold_res1", res1, COL_MIX_INV);

        // Capture isolation: block_in churns and start re-pulses while the block is in flight
        @(negedge clk_in);
        start    = 1'b1;
        block_in = BYTE_IDX;
        push(cyc + 1, BYTE_IDX_INV, 1'b1, 1'b1, 1'b1);
        @(negedge clk_in);
        start    = 1'b0;
        block_in = 128'hdeadbeef_01234567_89abcdef_55aa33cc;
        @(negedge clk_in);
        start    = 1'b1;
        block_in = {16{8'h63}};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            start    = 1'b0;
            block_in = {4{$urandom}};
        end
        idle(8);

        // Mid-SUB reset: only the 4-column instance finishes before reset hits
        @(negedge clk_in);
        start    = 1'b1;
        block_in = {16{8'hff}};
        push(cyc + 1, {16{8'h7d}}, 1'b0, 1'b0, 1'b1);
        @(negedge clk_in);
        start = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        check_zero_outputs("midsub_rst");
        idle(2);
        rst_in   = 1'b1;
        start    = 1'b1;
        block_in = COL_MIX;
        push(cyc + 1, COL_MIX_INV, 1'b1, 1'b1, 1'b1);
        @(negedge clk_in);
        start = 1'b0;
        idle(10);

        for (int i = 0; i < 3; i++)
            check_eq($sformatf("pending_dut%0d", i), 128'(q[i].size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
